// File: rtl/render_sequencer.sv
// render_sequencer: frame-level render controller.
// Runs a one-time object load, then per vsync: clear the back buffer, project
// and draw each object in turn, and swap buffers on the next vsync edge.
// Clear and draw pixel streams are muxed onto one frame-buffer write port.
module render_sequencer #(
  parameter int XW      = 10,
  parameter int NUM_OBJ = 4,
  parameter int OBJ_W   = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1,
  parameter int CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_clk,
  input  logic             enable,
  input  logic             load_done,
  input  logic             clear_done,
  input  logic             proj_done,
  input  logic             draw_done,
  input  logic [XW-1:0]    clear_DrawX,
  input  logic [XW-1:0]    clear_DrawY,
  input  logic             clear_we,
  input  logic [XW-1:0]    draw_DrawX,
  input  logic [XW-1:0]    draw_DrawY,
  input  logic             draw_we,
  output logic             load_obj,
  output logic             clear_start,
  output logic             proj_start,
  output logic             draw_start,
  output logic [OBJ_W-1:0] obj_sel,
  output logic [XW-1:0]    DrawX,
  output logic [XW-1:0]    DrawY,
  output logic             draw_data,
  output logic             pixel_we,
  output logic             frame_clk_rising_edge,
  output logic             frame_done,
  output logic             buf_sel,
  output logic             frame_overrun,
  output logic [CNT_W-1:0] frames_rendered
);

  typedef enum logic [2:0] {
    S_LOAD, S_IDLE, S_CLEAR, S_PROJ, S_DRAW, S_WAIT_SWAP
  } state_t;

  state_t           state, state_next;
  logic             entered;   // high in the first cycle spent in a state
  logic             booted;    // low only in the cycle right after reset release
  logic             waiting;   // done inputs are honoured only when set
  logic             fc_s1, fc_s2, fc_prev, rise;
  logic             last_obj;
  logic             swap;
  logic             busy;

  assign waiting  = booted & ~entered;
  assign last_obj = (obj_sel == OBJ_W'(NUM_OBJ - 1));
  assign swap     = (state == S_WAIT_SWAP) & rise;
  assign busy     = (state == S_CLEAR) | (state == S_PROJ) | (state == S_DRAW);
  assign frame_clk_rising_edge = rise;

  // Synchronise vsync and turn its rising edge into a registered one-cycle pulse.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fc_s1   <= 1'b0;
      fc_s2   <= 1'b0;
      fc_prev <= 1'b0;
      rise    <= 1'b0;
    end else begin
      fc_s1   <= frame_clk;
      fc_s2   <= fc_s1;
      fc_prev <= fc_s2;
      rise    <= fc_s2 & ~fc_prev;
    end
  end

  // State register; 'entered' marks the start-pulse cycle of each state,
  // including the LOAD state reached out of reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= S_LOAD;
      entered <= 1'b0;
      booted  <= 1'b0;
    end else begin
      state   <= state_next;
      booted  <= 1'b1;
      entered <= (state_next != state) | ~booted;
    end
  end

  // Next-state logic: engine handshakes and vsync-driven frame start/swap.
  always_comb begin
    state_next = state;
    case (state)
      S_LOAD:      if (waiting && load_done)  state_next = S_IDLE;
      S_IDLE:      if (rise && enable)        state_next = S_CLEAR;
      S_CLEAR:     if (waiting && clear_done) state_next = S_PROJ;
      S_PROJ:      if (waiting && proj_done)  state_next = S_DRAW;
      S_DRAW:      if (waiting && draw_done)  state_next = last_obj ? S_WAIT_SWAP : S_PROJ;
      S_WAIT_SWAP: if (rise)                  state_next = enable ? S_CLEAR : S_IDLE;
      default:                                state_next = S_LOAD;
    endcase
  end

  // Frame bookkeeping: object index, buffer swap, frame count and overrun flag.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      obj_sel         <= '0;
      buf_sel         <= 1'b0;
      frame_done      <= 1'b0;
      frames_rendered <= '0;
      frame_overrun   <= 1'b0;
    end else begin
      frame_done <= swap;
      if (swap) begin
        buf_sel         <= ~buf_sel;
        frames_rendered <= frames_rendered + CNT_W'(1);
      end
      // A vsync arriving before the frame reached WAIT_SWAP means it missed its slot.
      if (rise && busy)
        frame_overrun <= 1'b1;
      if (state == S_CLEAR && waiting && clear_done)
        obj_sel <= '0;
      else if (state == S_DRAW && waiting && draw_done && !last_obj)
        obj_sel <= obj_sel + OBJ_W'(1);
    end
  end

  // Output decode: start pulses and the zero-latency pixel write mux.
  always_comb begin
    load_obj    = (state == S_LOAD)  & entered;
    clear_start = (state == S_CLEAR) & entered;
    proj_start  = (state == S_PROJ)  & entered;
    draw_start  = (state == S_DRAW)  & entered;
    DrawX       = '0;
    DrawY       = '0;
    draw_data   = 1'b0;
    pixel_we    = 1'b0;
    case (state)
      S_CLEAR: begin
        DrawX    = clear_DrawX;
        DrawY    = clear_DrawY;
        pixel_we = clear_we;
      end
      S_DRAW: begin
        DrawX     = draw_DrawX;
        DrawY     = draw_DrawY;
        draw_data = 1'b1;
        pixel_we  = draw_we;
      end
      default: ;
    endcase
  end

endmodule
